// File: rtl/simple_axi_pkg.sv
// Shared types for simple_axi_master and its round-robin command arbiter.
package simple_axi_pkg;

    typedef enum logic [1:0] {
        RW_NOP   = 2'b00,
        RW_WRITE = 2'b01,
        RW_READ  = 2'b10
    } rw_cmd_e;

    typedef enum logic [2:0] {
        SZ_BYTE  = 3'd0,
        SZ_HALF  = 3'd1,
        SZ_WORD  = 3'd2,
        SZ_DWORD = 3'd3
    } transfer_size_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } arb_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/sam_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module sam_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
            if (!o_any && i_req[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = cand;
            end
        end
    end

endmodule

// File: rtl/simple_axi_master_arbiter.sv
// Round-robin arbiter sharing one simple_axi_master command port among N_REQ requesters.
// Define SIMPLE_AXI_ARB_STATS_EN to add saturating per-requester completion/error counters.
module simple_axi_master_arbiter
    import simple_axi_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*2-1:0]      i_req_rw,
    input  logic [N_REQ*3-1:0]      i_req_size,
    input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [N_REQ*DATA_W-1:0] i_req_wdata,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]       o_rsp_rdata,
    output logic                    o_rsp_error,
    output logic                    o_rsp_invalid,
    output logic                    o_busy,
    output logic [1:0]              m_rw,
    output logic [2:0]              m_size,
    output logic [ADDR_W-1:0]       m_addr,
    output logic [DATA_W-1:0]       m_wdata,
    output logic                    m_clear,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic                    m_wait,
    input  logic                    m_done,
    input  logic                    m_error,
    input  logic                    m_invalid
`ifdef SIMPLE_AXI_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]     o_stat_done,
    output logic [N_REQ*16-1:0]     o_stat_err
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [1:0]        rw_q, rw_d;
    logic [2:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic [N_REQ-1:0]  req_ready;
    logic              done_now;

    sam_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (rr_ptr_q),
        .o_grant (grant),
        .o_idx   (grant_idx),
        .o_any   (grant_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        rw_d      = rw_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_ready = '0;
        done_now  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    owner_d   = grant_idx;
                    state_d   = S_ISSUE;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant[i]) begin
                            rw_d    = i_req_rw[i*2 +: 2];
                            size_d  = i_req_size[i*3 +: 3];
                            addr_d  = i_req_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = i_req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            // A misaligned command is rejected by the master in the issue cycle itself.
            S_ISSUE: begin
                if (m_done) done_now = 1'b1;
                else        state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (m_done && !m_wait) done_now = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (done_now) begin
            state_d  = S_IDLE;
            rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    always_ff @(posedge i_clk) begin
        rw_q    <= rw_d;
        size_q  <= size_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Handshake strobes are masked during reset so an aborted transaction never reports.
    assign o_req_ready   = i_rst_n ? req_ready : '0;
    assign o_rsp_valid   = (done_now && i_rst_n) ? (N_REQ'(1) << owner_q) : '0;
    assign o_rsp_rdata   = done_now ? m_rdata : '0;
    assign o_rsp_error   = done_now & m_error;
    assign o_rsp_invalid = done_now & m_invalid;
    assign m_clear       = done_now & i_rst_n;
    assign o_busy        = (state_q != S_IDLE);
    assign m_rw          = (state_q == S_ISSUE) ? rw_q    : 2'b00;
    assign m_size        = (state_q == S_ISSUE) ? size_q  : 3'b000;
    assign m_addr        = (state_q == S_ISSUE) ? addr_q  : '0;
    assign m_wdata       = (state_q == S_ISSUE) ? wdata_q : '0;

`ifdef SIMPLE_AXI_ARB_STATS_EN
    logic [STAT_W-1:0] stat_done_q [N_REQ];
    logic [STAT_W-1:0] stat_done_d [N_REQ];
    logic [STAT_W-1:0] stat_err_q  [N_REQ];
    logic [STAT_W-1:0] stat_err_d  [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stat_done_d[i] = stat_done_q[i];
            stat_err_d[i]  = stat_err_q[i];
            if (o_rsp_valid[i] && (stat_done_q[i] != '1))
                stat_done_d[i] = stat_done_q[i] + 1'b1;
            if (o_rsp_valid[i] && o_rsp_error && (stat_err_q[i] != '1))
                stat_err_d[i] = stat_err_q[i] + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!i_rst_n) begin
                stat_done_q[i] <= '0;
                stat_err_q[i]  <= '0;
            end else begin
                stat_done_q[i] <= stat_done_d[i];
                stat_err_q[i]  <= stat_err_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign o_stat_done[g*16 +: 16] = stat_done_q[g];
        assign o_stat_err[g*16 +: 16]  = stat_err_q[g];
    end
`endif

endmodule

// File: tb/tb_simple_axi_master_arbiter.sv
// Self-checking bench for simple_axi_master_arbiter with a behavioural master model.
module tb_simple_axi_master_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [N-1:0]  i_req_valid = '0;
    logic [N-1:0]  o_req_ready;
    logic [N*2-1:0]  i_req_rw;
    logic [N*3-1:0]  i_req_size;
    logic [N*32-1:0] i_req_addr;
    logic [N*64-1:0] i_req_wdata;
    logic [N-1:0]  o_rsp_valid;
    logic [63:0]   o_rsp_rdata;
    logic          o_rsp_error, o_rsp_invalid, o_busy;
    logic [1:0]    m_rw;
    logic [2:0]    m_size;
    logic [31:0]   m_addr;
    logic [63:0]   m_wdata;
    logic          m_clear;
    logic [63:0]   m_rdata;
    logic          m_wait, m_done, m_error, m_invalid;
`ifdef SIMPLE_AXI_ARB_STATS_EN
    logic [N*16-1:0] o_stat_done, o_stat_err;
    int exp_done [N];
    int exp_err  [N];
`endif

    logic [1:0]  t_rw    [N];
    logic [2:0]  t_size  [N];
    logic [31:0] t_addr  [N];
    logic [63:0] t_wdata [N];

    int checks = 0;
    int failures = 0;
    int exp_ptr = 0;
    int e_cmds = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign i_req_rw[gi*2 +: 2]     = t_rw[gi];
        assign i_req_size[gi*3 +: 3]   = t_size[gi];
        assign i_req_addr[gi*32 +: 32] = t_addr[gi];
        assign i_req_wdata[gi*64 +: 64] = t_wdata[gi];
    end

    simple_axi_master_arbiter #(.N_REQ(N), .ADDR_W(32), .DATA_W(64)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_rw(i_req_rw), .i_req_size(i_req_size),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_error(o_rsp_error), .o_rsp_invalid(o_rsp_invalid),
        .o_busy(o_busy),
        .m_rw(m_rw), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_clear(m_clear),
        .m_rdata(m_rdata), .m_wait(m_wait), .m_done(m_done),
        .m_error(m_error), .m_invalid(m_invalid)
`ifdef SIMPLE_AXI_ARB_STATS_EN
        , .o_stat_done(o_stat_done), .o_stat_err(o_stat_err)
`endif
    );

    // Behavioural master: rejects misaligned commands in the issue cycle,
    // otherwise completes after a programmable wait and holds done until cleared.
    int          mdl_lat = 0;
    logic [63:0] mdl_rdata = '0;
    bit          mdl_slverr = 1'b0;
    logic        mst_busy = 1'b0, mst_done = 1'b0, mst_err = 1'b0;
    logic [63:0] mst_rdata = '0;
    int          mst_cnt = 0;
    int          mst_cmds = 0;
    wire misal_now = (m_rw != 2'b00) && ((m_addr & ((32'd1 << m_size) - 32'd1)) != 32'd0);

    assign m_done    = mst_done | misal_now;
    assign m_wait    = mst_busy & ~mst_done;
    assign m_rdata   = misal_now ? 64'd0 : mst_rdata;
    assign m_error   = misal_now | (mst_done & mst_err);
    assign m_invalid = misal_now;

    always @(posedge clk) begin
        if (i_rst_n && m_rw != 2'b00) mst_cmds <= mst_cmds + 1;
        if (!i_rst_n) begin
            mst_busy <= 1'b0; mst_done <= 1'b0; mst_err <= 1'b0; mst_rdata <= '0; mst_cnt <= 0;
        end else if (m_clear) begin
            mst_busy <= 1'b0; mst_done <= 1'b0;
        end else if (m_rw != 2'b00 && !misal_now && !mst_busy) begin
            mst_busy  <= 1'b1;
            mst_cnt   <= mdl_lat;
            mst_rdata <= (m_rw == 2'b10) ? mdl_rdata : 64'd0;
            mst_err   <= mdl_slverr;
        end else if (mst_busy && !mst_done) begin
            if (mst_cnt == 0) mst_done <= 1'b1;
            else              mst_cnt  <= mst_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending requester at or after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic rand_req(input int i);
        t_rw[i]    = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        t_size[i]  = 3'($urandom_range(0, 3));
        t_addr[i]  = $urandom & ~((32'd1 << t_size[i]) - 32'd1);
        t_wdata[i] = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_m_clear", m_clear, 0);
        chk("rst_m_addr", m_addr, 0);
        i_rst_n = 1'b1;
        exp_ptr = 0;
`ifdef SIMPLE_AXI_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin exp_done[i] = 0; exp_err[i] = 0; end
`endif
    endtask

    // Entered and left just after a falling edge with the arbiter idle.
    task automatic one_txn(input bit drop, input int lat, input logic [63:0] rd, input bit slverr);
        int g, c, bad;
        bit seen, misal, e_err;
        logic [1:0] e_rw; logic [2:0] e_size; logic [31:0] e_addr; logic [63:0] e_wdata, e_rdata;
        mdl_lat = lat; mdl_rdata = rd; mdl_slverr = slverr;
        #1;
        g = pick(i_req_valid, exp_ptr);
        chk("idle_busy", o_busy, 0);
        chk("grant", o_req_ready, 64'd1 << g);
        e_rw = t_rw[g]; e_size = t_size[g]; e_addr = t_addr[g]; e_wdata = t_wdata[g];
        misal = (e_addr % (32'd1 << e_size)) != 0;
        @(negedge clk);
        if (drop) i_req_valid[g] = 1'b0;
        rand_req(g);
        #1;
        chk("issue_m_rw", m_rw, e_rw);
        chk("issue_m_size", m_size, e_size);
        chk("issue_m_addr", m_addr, e_addr);
        chk("issue_m_wdata", m_wdata, e_wdata);
        chk("issue_busy", o_busy, 1);
        e_cmds++;
        bad = 0; c = 0;
        seen = (o_rsp_valid != 0);
        while (!seen && c < 50) begin
            @(negedge clk);
            #1;
            c++;
            seen = (o_rsp_valid != 0);
            if (!seen && (m_rw != 2'b00 || m_clear)) bad++;
        end
        chk("rsp_seen", seen, 1);
        if (misal) chk("misal_in_issue", c, 0);
        e_rdata = (misal || e_rw != 2'b10) ? 64'd0 : rd;
        e_err = misal || slverr;
        chk("rsp_valid", o_rsp_valid, 64'd1 << g);
        chk("rsp_rdata", o_rsp_rdata, e_rdata);
        chk("rsp_error", o_rsp_error, e_err);
        chk("rsp_invalid", o_rsp_invalid, misal);
        chk("done_m_clear", m_clear, 1);
        chk("wait_handshake", bad, 0);
        exp_ptr = (g + 1) % N;
`ifdef SIMPLE_AXI_ARB_STATS_EN
        exp_done[g]++;
        if (e_err) exp_err[g]++;
`endif
        @(negedge clk);
        #1;
        chk("after_m_clear", m_clear, 0);
        chk("after_rsp_valid", o_rsp_valid, 0);
        chk("after_busy", o_busy, 0);
    endtask

    initial begin
        int prev_g;
        for (int i = 0; i < N; i++) rand_req(i);
        do_reset();

        // Single read on requester 1
        t_rw[1] = 2'b10; t_size[1] = 3'd2; t_addr[1] = 32'h1004;
        i_req_valid = 4'b0010;
        one_txn(1'b1, 2, 64'hDEADBEEF, 1'b0);

        // All requesters held valid from reset, four grants each
        do_reset();
        i_req_valid = 4'b1111;
        prev_g = -1;
        for (int n = 0; n < 16; n++) begin
            int g;
            g = pick(i_req_valid, exp_ptr);
            chk("rr_order", g, n % N);
            chk("no_repeat", (g == prev_g), 0);
            prev_g = g;
            one_txn(n >= 12, $urandom_range(0, 3), {$urandom, $urandom}, 1'b0);
        end

        // Misaligned write on requester 2
        t_rw[2] = 2'b01; t_size[2] = 3'd3; t_addr[2] = 32'h1003;
        i_req_valid = 4'b0100;
        one_txn(1'b1, 0, 64'h0, 1'b0);

        // SLVERR write on requester 0, then normal traffic continues
        t_rw[0] = 2'b01; t_size[0] = 3'd3; t_addr[0] = 32'h2000;
        i_req_valid = 4'b0001;
        one_txn(1'b1, 1, 64'h0, 1'b1);
        t_rw[3] = 2'b10; t_size[3] = 3'd3; t_addr[3] = 32'h3008;
        i_req_valid = 4'b1000;
        one_txn(1'b1, 1, 64'h0123_4567_89AB_CDEF, 1'b0);
        i_req_valid = 4'b0010;
        one_txn(1'b1, 0, {$urandom, $urandom}, 1'b0);

        // Reset while waiting on the master
        t_rw[2] = 2'b10; t_size[2] = 3'd2; t_addr[2] = 32'h4000;
        i_req_valid = 4'b0100;
        mdl_lat = 8;
        #1;
        chk("rst_txn_grant", o_req_ready, 64'd1 << pick(i_req_valid, exp_ptr));
        @(negedge clk);
        i_req_valid = '0;
        e_cmds++;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_txn_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_txn_rsp_valid", o_rsp_valid, 0);
        chk("rst_txn_m_clear", m_clear, 0);
        @(negedge clk);
        #1;
        chk("rst_txn_idle", o_busy, 0);
        chk("rst_txn_m_rw", m_rw, 0);
        chk("rst_txn_rsp_after", o_rsp_valid, 0);
        i_rst_n = 1'b1;
        exp_ptr = 0;
`ifdef SIMPLE_AXI_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin exp_done[i] = 0; exp_err[i] = 0; end
`endif
        i_req_valid = 4'b1111;
        chk("first_grant_after_rst", pick(i_req_valid, exp_ptr), 0);
        one_txn(1'b1, 0, {$urandom, $urandom}, 1'b0);

        // Randomized request masks with random fields, latencies and errors
        for (int r = 0; r < 12; r++) begin
            i_req_valid = 4'($urandom_range(1, 15));
            while (i_req_valid != 0)
                one_txn(1'b1, $urandom_range(0, 4), {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end
        chk("master_cmd_count", mst_cmds, e_cmds);

        // Requester 3: three good completions and one error
        do_reset();
        for (int n = 0; n < 4; n++) begin
            rand_req(3);
            i_req_valid = 4'b1000;
            one_txn(1'b1, $urandom_range(0, 2), {$urandom, $urandom}, n == 2);
        end
`ifdef SIMPLE_AXI_ARB_STATS_EN
        chk("stat_done3_literal", o_stat_done[3*16 +: 16], 4);
        chk("stat_err3_literal", o_stat_err[3*16 +: 16], 1);
        for (int i = 0; i < N; i++) begin
            chk("stat_done", o_stat_done[i*16 +: 16], exp_done[i]);
            chk("stat_err", o_stat_err[i*16 +: 16], exp_err[i]);
        end
`endif
        chk("final_idle", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
